// File: rtl/kronos_pipe_stage.sv
// -----------------------------------------------------------------------------
// kronos_pipe_stage
//
// Purpose:
//   Multi-slot valid/ready pipestage for the Kronos core. A WIDTH-bit payload
//   moves through STAGES register slots, each with its own valid bit. Bubbles
//   collapse: a slot advances whenever the slot below it is empty or draining.
//   Global flush and a registered occupancy count are provided.
//
// Optional build feature:
//   KRONOS_PIPE_STAGE_SKID_EN - adds one skid entry in front of slot 0, so
//   that pipe_in_rdy no longer depends combinationally on pipe_out_rdy.
//   Occupancy then peaks at STAGES+1.
//
// Parameters:
//   WIDTH  - payload width in bits (>= 1)
//   STAGES - number of pipeline register slots (>= 1)
//
// Ports:
//   clk           in   core clock, rising edge
//   rstz          in   asynchronous active-low reset
//   flush         in   synchronous flush, drops every held entry
//   pipe_in_data  in   upstream payload
//   pipe_in_vld   in   upstream payload valid
//   pipe_in_rdy   out  payload accepted this cycle when valid
//   pipe_out_data out  payload of the last slot
//   pipe_out_vld  out  last slot valid
//   pipe_out_rdy  in   downstream accepts
//   occupancy     out  number of valid entries held (skid included)
//   busy          out  occupancy != 0
// -----------------------------------------------------------------------------
module kronos_pipe_stage #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rstz,
  input  logic                        flush,
  input  logic [WIDTH-1:0]            pipe_in_data,
  input  logic                        pipe_in_vld,
  output logic                        pipe_in_rdy,
  output logic [WIDTH-1:0]            pipe_out_data,
  output logic                        pipe_out_vld,
  input  logic                        pipe_out_rdy,
  output logic [$clog2(STAGES+2)-1:0] occupancy,
  output logic                        busy
);

  localparam int OCC_W = $clog2(STAGES + 2);

  // Refuse to elaborate degenerate configurations.
  generate
    if (STAGES < 1) begin : g_bad_stages
      $error("kronos_pipe_stage: STAGES must be at least 1");
    end
    if (WIDTH < 1) begin : g_bad_width
      $error("kronos_pipe_stage: WIDTH must be at least 1");
    end
  endgenerate

  // Slot state
  logic [STAGES-1:0] vld_reg;
  logic [STAGES-1:0] vld_next;
  logic [WIDTH-1:0]  data_reg [STAGES];

  // Per-slot transfer strobes and the payload each slot would load
  logic [STAGES-1:0] load;
  logic [WIDTH-1:0]  slot_in [STAGES];

  // rdy[i]: slot i can take a new entry this cycle. rdy[STAGES] is downstream.
  logic [STAGES:0]   rdy;

  // Source feeding slot 0 (skid entry or the raw input)
  logic              src_vld;
  logic [WIDTH-1:0]  src_data;

  logic [OCC_W-1:0]  occupancy_reg;
  logic [OCC_W-1:0]  occupancy_next;

  // Ready chain, evaluated from the output back toward the input. Kept in one
  // process so the bit-to-bit dependency resolves in a single pass.
  always_comb begin
    rdy[STAGES] = pipe_out_rdy;
    for (int i = STAGES - 1; i >= 0; i--) begin
      rdy[i] = ~vld_reg[i] | rdy[i+1];
    end
  end

`ifdef KRONOS_PIPE_STAGE_SKID_EN
  logic             skid_vld_reg;
  logic             skid_vld_next;
  logic [WIDTH-1:0] skid_data_reg;
  logic             in_xfer;
  logic             skid_load;

  // Input readiness depends only on local state, breaking the long
  // combinational path from pipe_out_rdy.
  assign pipe_in_rdy = ~skid_vld_reg & ~flush;
  assign in_xfer     = pipe_in_vld & pipe_in_rdy;

  // A parked entry is older than anything on the input, so it goes first.
  // An empty skid is bypassed so latency from an empty pipe is unchanged.
  assign src_vld     = skid_vld_reg | in_xfer;
  assign src_data    = skid_vld_reg ? skid_data_reg : pipe_in_data;

  // Accepted but slot 0 cannot take it: park it.
  assign skid_load   = in_xfer & ~rdy[0];

  always_comb begin
    skid_vld_next = skid_vld_reg;
    if (flush) begin
      skid_vld_next = 1'b0;
    end else if (skid_load) begin
      skid_vld_next = 1'b1;
    end else if (skid_vld_reg && rdy[0]) begin
      skid_vld_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      skid_vld_reg  <= 1'b0;
      skid_data_reg <= '0;
    end else begin
      skid_vld_reg <= skid_vld_next;
      if (skid_load) begin
        skid_data_reg <= pipe_in_data;
      end
    end
  end
`else
  assign pipe_in_rdy = rdy[0] & ~flush;
  assign src_vld     = pipe_in_vld & pipe_in_rdy;
  assign src_data    = pipe_in_data;
`endif

  // Per-slot transfer decode. Flush suppresses all movement so nothing is
  // loaded into a slot whose valid bit is about to be cleared.
  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_slot
      if (gi == 0) begin : g_head
        assign load[gi]    = src_vld & rdy[gi] & ~flush;
        assign slot_in[gi] = src_data;
      end else begin : g_body
        assign load[gi]    = vld_reg[gi-1] & rdy[gi] & ~flush;
        assign slot_in[gi] = data_reg[gi-1];
      end
      // A slot stays valid if it receives something, or if it holds an entry
      // that cannot move on.
      assign vld_next[gi] = ~flush & (load[gi] | (vld_reg[gi] & ~rdy[gi+1]));
    end
  endgenerate

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      vld_reg <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data_reg[i] <= '0;
      end
    end else begin
      vld_reg <= vld_next;
      for (int i = 0; i < STAGES; i++) begin
        if (load[i]) begin
          data_reg[i] <= slot_in[i];
        end
      end
    end
  end

  // Occupancy is registered from the next-state valid bits, so it tracks the
  // slot valids exactly, one cycle after the transfer that changed them.
  always_comb begin
    occupancy_next = '0;
    for (int i = 0; i < STAGES; i++) begin
      occupancy_next = occupancy_next + OCC_W'(vld_next[i]);
    end
`ifdef KRONOS_PIPE_STAGE_SKID_EN
    occupancy_next = occupancy_next + OCC_W'(skid_vld_next);
`endif
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      occupancy_reg <= '0;
    end else begin
      occupancy_reg <= occupancy_next;
    end
  end

  assign pipe_out_vld  = vld_reg[STAGES-1];
  assign pipe_out_data = data_reg[STAGES-1];
  assign occupancy     = occupancy_reg;
  assign busy          = (occupancy_reg != '0);

endmodule

// File: doc/kronos_pipe_stage.md
Name: kronos_pipe_stage

Overview:
- Parametrised, multi-stage valid/ready pipestage for the Kronos core: a successor to the single-register EX output stage.
- Carries a WIDTH-bit payload through STAGES register slots with per-slot valid bits.
- Bubbles collapse: a slot advances whenever the slot downstream is empty or draining.
- Provides global flush and an occupancy count. Used between ID/EX/WB and for multi-cycle execute units.

Parameters:
- WIDTH, 32, payload width in bits (>=1).
- STAGES, 2, number of pipeline register slots (>=1). A value of 0 is an elaboration error.

Ports:
- clk  input  1  core clock, all flops on rising edge.
- rstz  input  1  asynchronous active-low reset.
- flush  input  1  synchronous pipeline flush.
- pipe_in_data  input  WIDTH  upstream payload.
- pipe_in_vld  input  1  upstream payload valid.
- pipe_in_rdy  output  1  block accepts payload this cycle.
- pipe_out_data  output  WIDTH  payload in last slot.
- pipe_out_vld  output  1  last slot valid.
- pipe_out_rdy  input  1  downstream accepts.
- occupancy  output  $clog2(STAGES+2)  number of valid entries held, including the skid entry.
- busy  output  1  occupancy != 0.

Behaviour:
- Reset (rstz low, async):
  - all slot valid bits = 0 and all slot data = 0, so pipe_out_vld=0 and pipe_out_data=0;
  - occupancy=0, busy=0;
  - pipe_in_rdy=1 once rstz is high and flush is low.
- Slots are indexed 0..STAGES-1. Slot STAGES-1 drives pipe_out_data and pipe_out_vld.
- Ready chain:
  - rdy[STAGES] = pipe_out_rdy;
  - rdy[i] = ~vld[i] | rdy[i+1] (combinational, collapses bubbles).
- Slot 0 loads pipe_in_data when pipe_in_vld & pipe_in_rdy.
- Slot i>0 loads slot i-1 when vld[i-1] & rdy[i].
- A slot whose contents move on and which receives nothing clears its valid bit.
- Data registers load only on transfer; they are otherwise held.
- Latency:
  - empty pipe: input accepted at cycle N appears at pipe_out_vld at cycle N+STAGES;
  - throughput is 1 per cycle while pipe_out_rdy=1.
- Backpressure:
  - with pipe_out_rdy=0, the pipe fills to STAGES entries, then pipe_in_rdy=0;
  - no payload is dropped or duplicated.
- Simultaneous accept and drain while full: pipe_in_rdy=1 through the ready chain, and occupancy is unchanged.
- Flush:
  - dominates all other events; pipe_in_rdy is forced to 0 while flush=1;
  - next edge clears every valid bit, including the skid entry;
  - an output handshake in the flush cycle still counts for downstream;
  - data registers are not cleared.
- Occupancy:
  - registered popcount of valid bits (plus skid);
  - updates the cycle after each transfer;
  - never exceeds STAGES, or STAGES+1 with the skid.
- Reset mid-operation discards all contents immediately (async).

Optional Feature:
- Macro: KRONOS_PIPE_STAGE_SKID_EN.
- Defined:
  - adds one skid entry (data + valid) at the input;
  - pipe_in_rdy = ~skid_vld & ~flush, which removes the combinational path from pipe_out_rdy to pipe_in_rdy;
  - an input accepted while rdy[0]=0 parks in the skid;
  - the skid has priority into slot 0 over new input;
  - latency from an empty pipe is unchanged (the input bypasses an empty skid);
  - maximum occupancy is STAGES+1.
- Undefined: no skid entry; pipe_in_rdy is combinational as in the ready chain.

Test Plan:
- Reset, STAGES=2, WIDTH=32: drive 0xA5A5_0001..0xA5A5_0004 back-to-back with pipe_out_rdy=1 -> outputs appear in order starting 2 cycles after the first accept, one per cycle, occupancy steady at 2.
- Stall: pipe_out_rdy=0, push 5 values -> first 2 accepted, pipe_in_rdy=0 on the 3rd (3rd and 4th with skid), pipe_out_data=first value held; release -> all accepted values drain in order, none lost or repeated.
- Bubble collapse: push 0x11, idle 1 cycle, push 0x22 with pipe_out_rdy=0 -> after 2 more cycles both slots are valid (occupancy=2), 0x11 at the output.
- Full pipe with pipe_out_rdy=1 and pipe_in_vld=1 simultaneously -> pipe_in_rdy=1, occupancy stays 2, throughput 1/cycle.
- Flush with 2 valid entries while pipe_in_vld=1 -> pipe_in_rdy=0 that cycle; next cycle pipe_out_vld=0, occupancy=0, busy=0.
- Assert rstz=0 mid-stream -> pipe_out_vld, occupancy and pipe_out_data go to 0 without a clock edge; STAGES=1 regression repeats the first and second scenarios with latency 1.
